output_arbiter: RTL

OUTPUT_ARBITER -- requirements
Module: output_arbiter

---
 rtl/router_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/output_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router constants and the output-arbiter state type.
// Any logic that decodes the winner address imports these same values.
package router_pkg;

  localparam int NUM_PORTS = 16;
  localparam int ADDR_W    = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-priority-encode: the first set request found scanning upward from
// i_ptr (wrapping modulo NUM_PORTS) is the winner.
module rr_pick #(
  parameter int NUM_PORTS = router_pkg::NUM_PORTS,
  parameter int ADDR_W    = router_pkg::ADDR_W
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [ADDR_W-1:0]    i_ptr,
  output logic [ADDR_W-1:0]    o_winner,
  output logic                 o_found
);

  logic [ADDR_W-1:0] w_idx;
  logic              w_hit;

  // Scan in round-robin order; once a hit is latched later candidates are ignored.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    w_hit    = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx    = ADDR_W'((int'(i_ptr) + k) % NUM_PORTS);
      w_hit    = !o_found && i_req[w_idx];
      o_winner = w_hit ? w_idx : o_winner;
      o_found  = o_found | w_hit;
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Round-robin output-port arbiter: grants one requesting input at a time and
// holds the grant until the forwarded frame (frameo_n) completes.
module output_arbiter #(
  parameter int NUM_PORTS = router_pkg::NUM_PORTS,
  parameter int ADDR_W    = router_pkg::ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 frameo_n,
  output logic [NUM_PORTS-1:0] grant,
  output logic [ADDR_W-1:0]    Address,
  output logic                 active
);

  import router_pkg::*;

  arb_state_t           r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_ptr;
  logic                 r_active;
  logic [ADDR_W-1:0]    w_winner;
  logic                 w_found;
  logic [ADDR_W-1:0]    w_next_ptr;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  assign w_next_ptr = (r_addr == ADDR_W'(NUM_PORTS - 1)) ? '0 : (r_addr + ADDR_W'(1'b1));

  // Arbitration FSM; every output is a flop updated in the same transition that changes state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_addr   <= '0;
      r_ptr    <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state  <= GRANT;
            r_grant  <= NUM_PORTS'(1'b1) << w_winner;
            r_addr   <= w_winner;
            r_active <= 1'b1;
          end
        end
        GRANT: begin
          if (!frameo_n) begin
            r_state <= HOLD;
          end else if (!req[r_addr]) begin
            // Requester withdrew before its frame started: abort and still rotate.
            r_state  <= RELEASE;
            r_grant  <= '0;
            r_active <= 1'b0;
            r_ptr    <= w_next_ptr;
          end
        end
        HOLD: begin
          if (frameo_n) begin
            r_state  <= RELEASE;
            r_grant  <= '0;
            r_active <= 1'b0;
            r_ptr    <= w_next_ptr;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_grant  <= '0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign Address = r_addr;
  assign active  = r_active;

endmodule
